// File: rtl/sweep_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sweep_ctrl
// Drives a universal binary counter through triangle sweeps with endpoint
// dwell and a programmable repeat count. Macro SWEEP_CTRL_PAUSE_EN adds a
// pause input that freezes the sweep.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module sweep_ctrl #(
  parameter int N  = 8,
  parameter int DW = 4,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
`ifdef SWEEP_CTRL_PAUSE_EN
  input  logic          pause,
`endif
  input  logic [N-1:0]  start_val,
  input  logic [DW-1:0] dwell,
  input  logic [RW-1:0] repeats,
  input  logic          step_en,
  input  logic          min_tick,
  input  logic          max_tick,
  output logic          cnt_sync_clear,
  output logic          cnt_enable,
  output logic          cnt_load,
  output logic          cnt_up,
  output logic [N-1:0]  cnt_d,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    RUN_UP    = 3'd2,
    DWELL_TOP = 3'd3,
    RUN_DOWN  = 3'd4,
    DWELL_BOT = 3'd5,
    CLEAR     = 3'd6
  } state_t;

  state_t        state, state_next;
  logic [N-1:0]  sv_lat;
  logic [DW-1:0] dwell_lat, dwell_cnt;
  logic [RW-1:0] rep_lat, sweep_cnt, sweep_nxt;
  logic          hold, last_sweep;
  logic          latch_cfg, dwell_load, dwell_dec, sweep_inc, done_next;

`ifdef SWEEP_CTRL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign sweep_nxt  = sweep_cnt + 1'b1;
  // repeats==0 means run forever, so it can never match the final sweep
  assign last_sweep = (rep_lat != '0) && (sweep_nxt == rep_lat);
  assign cnt_d      = sv_lat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sv_lat    <= '0;
      dwell_lat <= '0;
      rep_lat   <= '0;
      dwell_cnt <= '0;
      sweep_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
      if (latch_cfg) begin
        sv_lat    <= start_val;
        dwell_lat <= dwell;
        rep_lat   <= repeats;
        sweep_cnt <= '0;
      end else if (sweep_inc) begin
        sweep_cnt <= sweep_nxt;
      end
      if (dwell_load) dwell_cnt <= dwell_lat;
      else if (dwell_dec) dwell_cnt <= dwell_cnt - 1'b1;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_sync_clear = 1'b0;
    cnt_enable     = 1'b0;
    cnt_load       = 1'b0;
    cnt_up         = 1'b0;
    busy           = (state != IDLE);
    latch_cfg      = 1'b0;
    dwell_load     = 1'b0;
    dwell_dec      = 1'b0;
    sweep_inc      = 1'b0;
    done_next      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          latch_cfg  = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        cnt_load   = 1'b1;
        cnt_up     = 1'b1;
        state_next = RUN_UP;
      end
      RUN_UP: begin
        cnt_up = 1'b1;
        if (!hold) begin
          cnt_enable = step_en & ~max_tick;
          if (max_tick) begin
            dwell_load = 1'b1;
            state_next = DWELL_TOP;
          end
        end
      end
      DWELL_TOP: begin
        cnt_up = 1'b1;
        if (!hold) begin
          if (dwell_cnt == '0) state_next = RUN_DOWN;
          else if (step_en)    dwell_dec  = 1'b1;
        end
      end
      RUN_DOWN: begin
        if (!hold) begin
          cnt_enable = step_en & ~min_tick;
          if (min_tick) begin
            if (last_sweep) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              sweep_inc  = 1'b1;
              dwell_load = 1'b1;
              state_next = DWELL_BOT;
            end
          end
        end
      end
      DWELL_BOT: begin
        if (!hold) begin
          if (dwell_cnt == '0) state_next = RUN_UP;
          else if (step_en)    dwell_dec  = 1'b1;
        end
      end
      CLEAR: begin
        cnt_sync_clear = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Abort wins over any transition chosen above; CLEAR itself always exits
    if (stop && state != IDLE && state != CLEAR) begin
      state_next = CLEAR;
      done_next  = 1'b0;
      dwell_load = 1'b0;
      dwell_dec  = 1'b0;
      sweep_inc  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sweep_ctrl.sv
`default_nettype none
// Bench for sweep_ctrl (N=4) with a behavioural counter in the loop; a
// procedural sweep model predicts every cycle of each programmed run.
module tb_sweep_ctrl;
  localparam int N    = 4;
  localparam int DW   = 4;
  localparam int RW   = 4;
  localparam int MAXV = (1 << N) - 1;

  logic          clk = 1'b0;
  logic          reset, start, stop, step_en;
  logic [N-1:0]  start_val;
  logic [DW-1:0] dwell;
  logic [RW-1:0] repeats;
  logic          min_tick, max_tick;
  logic          cnt_sync_clear, cnt_enable, cnt_load, cnt_up, busy, done;
  logic [N-1:0]  cnt_d, q;
`ifdef SWEEP_CTRL_PAUSE_EN
  logic          pause = 1'b0;
`endif

  int vecs = 0;
  int errs = 0;

  typedef struct packed {
    logic busy, load, en, up, clr, done;
    logic [N-1:0] q, d;
  } obs_t;

  typedef struct {
    logic [N-1:0] sv;
    int dw, rep, period;
    int ups, downs, dones, busys;
  } vec_t;

  bit           steps[8192];
  obs_t         exp_q[$];
  logic [N-1:0] last_sv = '0;

  sweep_ctrl #(.N(N), .DW(DW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
`ifdef SWEEP_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .start_val(start_val), .dwell(dwell), .repeats(repeats), .step_en(step_en),
    .min_tick(min_tick), .max_tick(max_tick),
    .cnt_sync_clear(cnt_sync_clear), .cnt_enable(cnt_enable), .cnt_load(cnt_load),
    .cnt_up(cnt_up), .cnt_d(cnt_d), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Downstream universal counter sharing the same reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               q <= '0;
    else if (cnt_sync_clear) q <= '0;
    else if (cnt_load)       q <= cnt_d;
    else if (cnt_enable)     q <= cnt_up ? q + 1'b1 : q - 1'b1;
  end
  assign min_tick = (q == '0);
  assign max_tick = (q == N'(MAXV));

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.load = cnt_load; o.en = cnt_enable; o.up = cnt_up;
    o.clr = cnt_sync_clear; o.done = done; o.q = q; o.d = cnt_d;
    return o;
  endfunction

  function automatic obs_t mk(bit b, bit l, bit e, bit u, bit c, bit dn, int qv, logic [N-1:0] dv);
    obs_t o;
    o.busy = b; o.load = l; o.en = e; o.up = u; o.clr = c; o.done = dn;
    o.q = N'(qv); o.d = dv;
    return o;
  endfunction

  task automatic check(string nm, obs_t got, obs_t want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got busy=%b load=%b en=%b up=%b clr=%b done=%b q=%0d d=%0d, expected busy=%b load=%b en=%b up=%b clr=%b done=%b q=%0d d=%0d",
               nm, got.busy, got.load, got.en, got.up, got.clr, got.done, got.q, got.d,
               want.busy, want.load, want.en, want.up, want.clr, want.done, want.q, want.d);
    end
  endtask

  task automatic chk(string nm, int got, int want);
    vecs++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // Expected per-cycle trace of one run: walk the sweep phases using the step pattern
  task automatic build_model(input logic [N-1:0] sv, input int dw, input int rep, input logic [N-1:0] d0);
    int c = 0, qq = 0, sweeps = 0, d;
    bit finished = 0;
    exp_q.delete();
    exp_q.push_back(mk(0,0,0,0,0,0,qq,d0)); c++;
    exp_q.push_back(mk(1,1,0,1,0,0,qq,sv)); c++;
    qq = sv;
    while (!finished) begin
      while (qq != MAXV) begin
        exp_q.push_back(mk(1,0,steps[c],1,0,0,qq,sv));
        if (steps[c]) qq++;
        c++;
      end
      exp_q.push_back(mk(1,0,0,1,0,0,qq,sv)); c++;
      d = dw;
      forever begin
        exp_q.push_back(mk(1,0,0,1,0,0,qq,sv));
        if (d == 0) begin c++; break; end
        if (steps[c]) d--;
        c++;
      end
      while (qq != 0) begin
        exp_q.push_back(mk(1,0,steps[c],0,0,0,qq,sv));
        if (steps[c]) qq--;
        c++;
      end
      exp_q.push_back(mk(1,0,0,0,0,0,qq,sv)); c++;
      sweeps++;
      if (rep != 0 && sweeps == rep) begin
        finished = 1;
      end else begin
        d = dw;
        forever begin
          exp_q.push_back(mk(1,0,0,0,0,0,qq,sv));
          if (d == 0) begin c++; break; end
          if (steps[c]) d--;
          c++;
        end
      end
    end
    exp_q.push_back(mk(0,0,0,0,0,1,0,sv));
    exp_q.push_back(mk(0,0,0,0,0,0,0,sv));
  endtask

  task automatic fill_steps(input int period);
    for (int c = 0; c < 8192; c++)
      steps[c] = (period == 0) ? ($urandom_range(0, 2) != 0) : ((c % period) == 0);
  endtask

  task automatic run_job(input string nm, input logic [N-1:0] sv, input int dw, input int rep,
                         output int ups, output int downs, output int dones, output int busys);
    obs_t got;
    build_model(sv, dw, rep, last_sv);
    ups = 0; downs = 0; dones = 0; busys = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      start     = (k == 0);
      // After the start cycle the config inputs wander; the DUT must use its latches
      start_val = (k == 0) ? sv : N'($urandom);
      dwell     = (k == 0) ? DW'(dw) : DW'($urandom);
      repeats   = (k == 0) ? RW'(rep) : RW'($urandom);
      step_en   = steps[k];
      #1;
      got = sample();
      check($sformatf("%s cyc%0d", nm, k), got, exp_q[k]);
      if (got.en && got.up)  ups++;
      if (got.en && !got.up) downs++;
      if (got.done)          dones++;
      if (got.busy)          busys++;
    end
    start   = 1'b0;
    last_sv = sv;
  endtask

  initial begin
    vec_t tbl[5];
    obs_t got;
    int ups, downs, dones, busys, k;

    tbl[0] = '{sv:3,  dw:0, rep:1, period:1, ups:12, downs:15, dones:1, busys:31};
    tbl[1] = '{sv:15, dw:2, rep:1, period:1, ups:0,  downs:15, dones:1, busys:21};
    tbl[2] = '{sv:0,  dw:1, rep:3, period:1, ups:45, downs:45, dones:1, busys:107};
    tbl[3] = '{sv:5,  dw:0, rep:1, period:4, ups:10, downs:15, dones:1, busys:-1};
    tbl[4] = '{sv:15, dw:0, rep:2, period:1, ups:15, downs:30, dones:1, busys:53};

    reset = 1'b1; start = 1'b0; stop = 1'b0; step_en = 1'b0;
    start_val = '0; dwell = '0; repeats = '0;
    #1;
    check("reset_during", sample(), mk(0,0,0,0,0,0,0,0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_after", sample(), mk(0,0,0,0,0,0,0,0));

    for (int i = 0; i < 5; i++) begin
      fill_steps(tbl[i].period);
      run_job($sformatf("tbl%0d", i), tbl[i].sv, tbl[i].dw, tbl[i].rep, ups, downs, dones, busys);
      chk($sformatf("tbl%0d up_steps", i), ups, tbl[i].ups);
      chk($sformatf("tbl%0d down_steps", i), downs, tbl[i].downs);
      chk($sformatf("tbl%0d done_pulses", i), dones, tbl[i].dones);
      if (tbl[i].busys >= 0) chk($sformatf("tbl%0d busy_cycles", i), busys, tbl[i].busys);
    end

    // Stop mid up-sweep at q=7; a start while busy must not reload
    @(negedge clk);
    start = 1'b1; start_val = '0; dwell = '0; repeats = '0; step_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 check("stop_seq load", sample(), mk(1,1,0,1,0,0,0,0));
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      start = (q == 4'd3);
      start_val = 4'd9;
      if (q == 4'd7) stop = 1'b1;
      #1 got = sample();
      if (start) chk("start_while_busy load", got.load, 0);
      if (stop) break;
      k++;
    end
    chk("stop_seq reached_q7", (k < 40) ? 1 : 0, 1);
    check("stop_seq stop_cycle", got, mk(1,0,1,1,0,0,7,0));
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    #1 check("stop_seq clear", sample(), mk(1,0,0,0,1,0,8,0));
    @(negedge clk);
    #1 check("stop_seq idle", sample(), mk(0,0,0,0,0,0,0,0));
    @(negedge clk);
    #1 check("stop_seq no_done", sample(), mk(0,0,0,0,0,0,0,0));
    last_sv = '0;

    // Start and stop together in IDLE: start wins; stop during LOAD then aborts
    @(negedge clk);
    start = 1'b1; stop = 1'b1; start_val = 4'd5;
    #1 check("start_stop idle", sample(), mk(0,0,0,0,0,0,0,0));
    @(negedge clk);
    start = 1'b0;
    #1 check("start_stop load", sample(), mk(1,1,0,1,0,0,0,5));
    @(negedge clk);
    stop = 1'b0;
    #1 check("start_stop clear", sample(), mk(1,0,0,0,1,0,5,5));
    @(negedge clk);
    #1 check("start_stop idle2", sample(), mk(0,0,0,0,0,0,0,5));
    last_sv = 4'd5;

    for (int r = 0; r < 15; r++) begin
      logic [N-1:0] sv;
      int dw, rep;
      sv  = N'($urandom);
      dw  = $urandom_range(0, 3);
      rep = $urandom_range(1, 3);
      fill_steps($urandom_range(0, 3));
      run_job($sformatf("rnd%0d", r), sv, dw, rep, ups, downs, dones, busys);
      chk($sformatf("rnd%0d done_pulses", r), dones, 1);
    end

`ifdef SWEEP_CTRL_PAUSE_EN
    // Pause in RUN_DOWN at q=9 freezes the counter, then the sweep finishes
    @(negedge clk);
    start = 1'b1; start_val = 4'd15; dwell = '0; repeats = 4'd1; step_en = 1'b1;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      start = 1'b0;
      if (q == 4'd9 && busy && !cnt_up) begin
        pause = 1'b1;
        break;
      end
      k++;
    end
    chk("pause reached_q9", (k < 40) ? 1 : 0, 1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1 check($sformatf("pause hold%0d", i), sample(), mk(1,0,0,0,0,0,9,15));
    end
    @(negedge clk);
    pause = 1'b0;
    k = 0;
    while (k < 40 && !done) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("pause resumed_done", done, 1);
    chk("pause final_q", q, 0);
    last_sv = 4'd15;
`endif

    // Reset mid-sweep clears everything at once
    @(negedge clk);
    start = 1'b1; start_val = 4'd2; repeats = '0; step_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1 check("reset_mid", sample(), mk(0,0,0,0,0,0,0,0));
    @(negedge clk);
    reset = 1'b0;
    #1 check("reset_mid_after", sample(), mk(0,0,0,0,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
